ripple_adder_reg: RTL and testbench
===================================

Name: ripple_adder_reg

Overview:
- Registered ripple-carry adder: adds two WIDTH-bit operands plus a carry-in and produces a WIDTH-bit sum and a carry-out.
- Built as a chain of 1-bit full-adder cells with the result captured in an output register.
- Used as a small arithmetic leaf; the default configuration is 4 bits, matching the existing 4-bit adder usage in the design.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands are valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- out_valid  output  1  sum/carry hold a freshly computed result.
- sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
- carry  output  1  registered carry-out, bit WIDTH of a+b+cin.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset: while rst=1 at a rising edge, sum=0, carry=0, out_valid=0. Reset has priority over in_valid.
- Combinational core:
  - c[0]=cin.
  - For bit i: s[i]=a[i]^b[i]^c[i]; c[i+1]=(a[i]&b[i])|(c[i]&(a[i]^b[i])).
  - carry_next=c[WIDTH].
- Latency: exactly 1 cycle. Inputs sampled at edge N with in_valid=1 appear on sum/carry at edge N, with out_valid=1 from edge N until the next edge.
- in_valid=0 at an edge: sum/carry hold their previous values; out_valid goes to 0.
- Back-to-back: one result per cycle with no bubbles; there is no backpressure.
- Wrap-around: results are modulo 2^WIDTH, with the overflow bit reported on carry. Example: a=all ones, b=0, cin=1 gives sum=0, carry=1.
- Reset mid-operation: an operation accepted in the same cycle that rst=1 is discarded.
- X/unknown inputs are only don't-care while in_valid=0.
- No internal state other than the output registers.

Optional Feature:
- Macro ADDER_OVERFLOW_FLAG_EN.
- When defined:
  - Adds output port ovf (1 bit), registered alongside sum.
  - ovf = c[WIDTH] ^ c[WIDTH-1] (two's-complement signed overflow).
  - Reset value 0; holds its value when in_valid=0.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package adder_pkg:
  - Constant ADDER_DEFAULT_WIDTH=4.
  - Typedef for the result struct {carry, sum}, sized by the package default.
- Sub-module full_adder_bit: 1-bit cell with inputs a, b, ci and outputs s, co, purely combinational.
- ripple_adder_reg instantiates WIDTH copies of full_adder_bit via a generate loop, plus the output register stage.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, a=4'hF, b=4'hF, cin=1 -> sum=0, carry=0, out_valid=0.
- Zero case: a=0, b=0, cin=0, in_valid=1 -> next edge sum=4'h0, carry=0, out_valid=1.
- Carry wrap: a=4'hF, b=4'h1, cin=0 -> sum=4'h0, carry=1.
- Max case: a=4'hF, b=4'hF, cin=1 -> sum=4'hF, carry=1. With ADDER_OVERFLOW_FLAG_EN defined, ovf=0.
- Hold and signed overflow:
  - a=4'h5, b=4'h3, cin=1 -> sum=4'h9, carry=0, with ovf=1 when the macro is defined.
  - Then drop in_valid -> sum stays 4'h9, out_valid=0.
- Random regression: 10+ back-to-back random a/b/cin with in_valid=1 -> each result equals {carry,sum}=a+b+cin, one cycle later, with no gaps.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and result type for the registered ripple-carry adder.
//   ADDER_DEFAULT_WIDTH : default operand width used by ripple_adder_reg
//   adder_result_t      : {carry, sum} result payload at the default width
package adder_pkg;

  localparam int unsigned ADDER_DEFAULT_WIDTH = 4;

  typedef struct packed {
    logic                           carry;
    logic [ADDER_DEFAULT_WIDTH-1:0] sum;
  } adder_result_t;

endpackage : adder_pkg

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell, purely combinational.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term, shared by the sum and the carry chain.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule : full_adder_bit

// File: rtl/ripple_adder_reg.sv
// Registered ripple-carry adder: sum/carry = a + b + cin, one cycle latency.
// Optional feature macro: ADDER_OVERFLOW_FLAG_EN adds the signed-overflow
// output ovf, registered alongside sum.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : operands valid this cycle
//   a, b      : WIDTH-bit unsigned operands
//   cin       : carry in
//   out_valid : sum/carry hold a result captured at the last edge
//   sum       : registered (a+b+cin) mod 2^WIDTH
//   carry     : registered carry out
//   ovf       : registered two's-complement overflow (macro only)
module ripple_adder_reg
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
`ifdef ADDER_OVERFLOW_FLAG_EN
  output logic             ovf,
`endif
  output logic             carry
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_c;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] sum_d,   sum_q;
  logic             carry_d, carry_q;
`ifdef ADDER_OVERFLOW_FLAG_EN
  logic             ovf_d,   ovf_q;
`endif

  // Carry chain: c[i] feeds bit i, c[WIDTH] is the carry out.
  assign c[0] = cin;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    full_adder_bit u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s_c[i]),
      .co (c[i+1])
    );
  end

  // Next-state: capture on in_valid, otherwise hold the last result.
  always_comb begin
    valid_d = in_valid;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef ADDER_OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    if (in_valid) begin
      sum_d   = s_c;
      carry_d = c[WIDTH];
`ifdef ADDER_OVERFLOW_FLAG_EN
      // Signed overflow: carry into the MSB differs from carry out of it.
      ovf_d   = c[WIDTH] ^ c[WIDTH-1];
`endif
    end
  end

  // Output register; reset wins over an operation in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef ADDER_OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef ADDER_OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
`ifdef ADDER_OVERFLOW_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule : ripple_adder_reg

// File: tb/tb_ripple_adder_reg.sv
// Directed self-checking bench for ripple_adder_reg at the default width.
// Build with ADDER_OVERFLOW_FLAG_EN defined to also check ovf.
module tb_ripple_adder_reg;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         carry;
`ifdef ADDER_OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  ripple_adder_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum       (sum),
`ifdef ADDER_OVERFLOW_FLAG_EN
    .ovf       (ovf),
`endif
    .carry     (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation at the falling edge, sample after the next rise.
  task automatic apply(input logic v, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic cv);
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = cv;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 4'hF, 4'hF, 1'b1);
      checks++;
      if (sum !== 4'h0 || carry !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset%0d: sum=%h carry=%b out_valid=%b, want 0 0 0",
                 i, sum, carry, out_valid);
      end
`ifdef ADDER_OVERFLOW_FLAG_EN
      checks++;
      if (ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset_ovf%0d: ovf=%b, want 0", i, ovf);
      end
`endif
    end
    rst = 1'b0;
  endtask

  task automatic test_zero();
    apply(1'b1, 4'h0, 4'h0, 1'b0);
    checks++;
    if (sum !== 4'h0 || carry !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero: sum=%h carry=%b out_valid=%b, want 0 0 1",
               sum, carry, out_valid);
    end
  endtask

  task automatic test_carry_wrap();
    apply(1'b1, 4'hF, 4'h1, 1'b0);
    checks++;
    if (sum !== 4'h0 || carry !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL carry_wrap: sum=%h carry=%b out_valid=%b, want 0 1 1",
               sum, carry, out_valid);
    end
    // All ones plus carry-in only.
    apply(1'b1, 4'hF, 4'h0, 1'b1);
    checks++;
    if (sum !== 4'h0 || carry !== 1'b1) begin
      errors++;
      $display("FAIL cin_wrap: sum=%h carry=%b, want 0 1", sum, carry);
    end
  endtask

  task automatic test_max();
    apply(1'b1, 4'hF, 4'hF, 1'b1);
    checks++;
    if (sum !== 4'hF || carry !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL max: sum=%h carry=%b out_valid=%b, want f 1 1",
               sum, carry, out_valid);
    end
`ifdef ADDER_OVERFLOW_FLAG_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL max_ovf: ovf=%b, want 0", ovf);
    end
`endif
  endtask

  task automatic test_hold();
    apply(1'b1, 4'h5, 4'h3, 1'b1);
    checks++;
    if (sum !== 4'h9 || carry !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_case: sum=%h carry=%b out_valid=%b, want 9 0 1",
               sum, carry, out_valid);
    end
`ifdef ADDER_OVERFLOW_FLAG_EN
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: ovf=%b, want 1", ovf);
    end
`endif
    // Inputs change while in_valid is low: result must not move.
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 4'hF, 4'hF, 1'b1);
      checks++;
      if (sum !== 4'h9 || carry !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: sum=%h carry=%b out_valid=%b, want 9 0 0",
                 i, sum, carry, out_valid);
      end
`ifdef ADDER_OVERFLOW_FLAG_EN
      checks++;
      if (ovf !== 1'b1) begin
        errors++;
        $display("FAIL hold_ovf%0d: ovf=%b, want 1", i, ovf);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_op();
    apply(1'b1, 4'h7, 4'h2, 1'b0);
    checks++;
    if (sum !== 4'h9 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_mid_reset: sum=%h out_valid=%b, want 9 1", sum, out_valid);
    end
    rst = 1'b1;
    apply(1'b1, 4'hC, 4'hC, 1'b1);
    rst = 1'b0;
    checks++;
    if (sum !== 4'h0 || carry !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: sum=%h carry=%b out_valid=%b, want 0 0 0",
               sum, carry, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av, bv;
    logic         cv;
    logic [W:0]   exp;
    int           sv;
    logic         exp_ovf;
    for (int i = 0; i < 16; i++) begin
      av  = W'($urandom_range(0, 15));
      bv  = W'($urandom_range(0, 15));
      cv  = 1'($urandom_range(0, 1));
      exp = (W+1)'(av) + (W+1)'(bv) + (W+1)'(cv);
      sv  = int'($signed(av)) + int'($signed(bv)) + int'(cv);
      exp_ovf = (sv > 7) || (sv < -8);
      apply(1'b1, av, bv, cv);
      checks++;
      if ({carry, sum} !== exp || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b%0d: %h+%h+%b got {carry,sum}=%h out_valid=%b, want %h 1",
                 i, av, bv, cv, {carry, sum}, out_valid, exp);
      end
`ifdef ADDER_OVERFLOW_FLAG_EN
      checks++;
      if (ovf !== exp_ovf) begin
        errors++;
        $display("FAIL b2b_ovf%0d: %h+%h+%b ovf=%b, want %b",
                 i, av, bv, cv, ovf, exp_ovf);
      end
`else
      if (exp_ovf === 1'bx) $display("unexpected x in model");
`endif
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    @(negedge clk);
    test_reset();
    test_zero();
    test_carry_wrap();
    test_max();
    test_hold();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ripple_adder_reg
